// File: rtl/mem_arb_pkg.sv
// Shared state encoding, requester indices and timeout fill data for the memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ASSERT  = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  localparam logic REQ_CACHE = 1'b0;
  localparam logic REQ_WALK  = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_req_arbiter_ack_sync.sv
// mem_ack_sync: STAGES-deep synchronizer for the memory's asynchronous ack; cleared by reset.
// Latency STAGES cycles; no backpressure.
module mem_ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin two-port sequencer for a req/ack memory; MEMARB_TIMEOUT_EN adds a handshake watchdog.
// ready->done latency 3+2*SYNC_STAGES cycles; requesters hold valid until ready, one access in flight.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_request,
  output logic              mem_we,
  input  logic              mem_ack
);

  arb_state_t        state_q, state_d;
  logic              ack_sync;
  logic              gnt_q, gnt_d, last_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              tmo, tmo_abort;

  mem_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mem_ack),
    .sync_out (ack_sync)
  );

  // On contention the requester that was not served last wins.
  assign gnt_d = (req0_valid && req1_valid) ? ~last_q : req1_valid;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign tmo       = (state_q == ASSERT || state_q == RELEASE) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign tmo_abort = tmo && err_q && (state_q == RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q || tmo) cnt_q <= '0;
      else if (state_q == ASSERT || state_q == RELEASE) cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE) err_q <= 1'b0;
      else if (tmo) err_q <= 1'b1;
    end
  end

  assign req0_err = req0_done && err_q;
  assign req1_err = req1_done && err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo            = 1'b0;
  assign tmo_abort      = 1'b0;
  assign req0_err       = 1'b0;
  assign req1_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ack_sync && (req0_valid || req1_valid)) state_d = SETUP;
      SETUP:   state_d = ASSERT;
      ASSERT:  if (tmo) state_d = DONE;
               else if (ack_sync) state_d = RELEASE;
      RELEASE: if (!ack_sync) state_d = DONE;
               else if (tmo_abort) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    req0_done    = 1'b0;
    req1_done    = 1'b0;
    mem_request  = 1'b0;
    mem_we       = 1'b0;
    mem_wdata_oe = 1'b0;
    case (state_q)
      SETUP: begin
        req0_ready   = (gnt_q == REQ_CACHE);
        req1_ready   = (gnt_q == REQ_WALK);
        mem_we       = we_q;
        mem_wdata_oe = we_q;
      end
      ASSERT: begin
        mem_request  = 1'b1;
        mem_we       = we_q;
        mem_wdata_oe = we_q;
      end
      RELEASE: begin
        mem_we       = we_q;
        mem_wdata_oe = we_q;
      end
      DONE: begin
        req0_done = (gnt_q == REQ_CACHE);
        req1_done = (gnt_q == REQ_WALK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= REQ_CACHE;
      last_q  <= REQ_WALK;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == SETUP) begin
        gnt_q   <= gnt_d;
        we_q    <= gnt_d ? req1_we    : req0_we;
        addr_q  <= gnt_d ? req1_addr  : req0_addr;
        wdata_q <= gnt_d ? req1_wdata : req0_wdata;
      end
      if (tmo) rdata_q <= DATA_W'(TIMEOUT_DATA);
      else if (state_q == ASSERT && ack_sync && !we_q) rdata_q <= mem_rdata;
      if (state_q == DONE || tmo_abort) last_q <= gnt_q;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench: async memory model, directed table, hand sequences and randomized traffic vs a reference model.
module tb_mem_req_arbiter;

  localparam int SS  = 2;
  localparam int TMO = 64;
  localparam int LAT = 3 + 2 * SS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_wdata_oe, mem_request, mem_we;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata), .mem_request(mem_request), .mem_we(mem_we), .mem_ack(mem_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Initial memory contents, word-indexed by addr[15:2].
  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      'h400:   return 32'h0000_2001;
      'h800:   return 32'h0000_3001;
      'h801:   return 32'h0000_4001;
      'h80C:   return 32'h0000_F001;
      default: return 32'hC0DE_0000 | 32'(idx);
    endcase
  endfunction

  // Asynchronous memory: samples on request rise, acks 1 ns after each request edge.
  logic [31:0] mem_arr [int];
  bit          ack_stuck = 0;
  int          oe_viol_mem = 0;
  int          oe_viol_mon = 0;

  always begin
    @(mem_request);
    if (mem_request === 1'b1) begin
      if (mem_we) begin
        if (mem_wdata_oe !== 1'b1) oe_viol_mem++;
        mem_arr[int'(mem_addr[15:2])] = mem_wdata;
      end else begin
        mem_rdata = mem_arr.exists(int'(mem_addr[15:2])) ? mem_arr[int'(mem_addr[15:2])]
                                                         : init_word(int'(mem_addr[15:2]));
      end
      #1;
      if (!ack_stuck) mem_ack = 1'b1;
    end else begin
      #1;
      mem_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_wdata_oe && !mem_we) oe_viol_mon++;
      if (mem_request && mem_we && !mem_wdata_oe) oe_viol_mon++;
    end
  end

  // Reference model: memory image, last granted requester, last returned read data.
  logic [31:0] ref_mem [int];
  int          last_grant = 1;
  logic [31:0] last_rdata = 32'h0;

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int k;
    k = int'(addr[15:2]);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic rdy(input int r);
    return (r == 0) ? req0_ready : req1_ready;
  endfunction
  function automatic logic dn(input int r);
    return (r == 0) ? req0_done : req1_done;
  endfunction
  function automatic logic er(input int r);
    return (r == 0) ? req0_err : req1_err;
  endfunction

  task automatic issue(input int r, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (r == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  task automatic drop(input int r);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Waits for requester r to be accepted and completed; checks timing, oe window and data.
  task automatic serve(input int r, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit use_exp, input logic [31:0] exp_tbl, input string tag);
    int n;
    bit got, other_rdy, oe_bad;
    logic [31:0] exp;
    got = 0; other_rdy = 0; n = 0;
    while (n < 50 && !got) begin
      @(negedge clk);
      n++;
      if (rdy(r)) got = 1;
      if (rdy(1 - r)) other_rdy = 1;
    end
    chk($sformatf("%s.ready", tag), 64'(got), 64'd1);
    chk($sformatf("%s.other_ready", tag), 64'(other_rdy), 64'd0);
    if (!got) begin
      drop(r);
      return;
    end
    oe_bad = (mem_wdata_oe !== we) || (mem_request !== 1'b0);
    drop(r);
    got = 0; n = 0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (dn(r)) got = 1;
      else if (mem_wdata_oe !== we) oe_bad = 1;
    end
    chk($sformatf("%s.done", tag), 64'(got), 64'd1);
    chk($sformatf("%s.latency", tag), 64'(n), 64'(LAT));
    chk($sformatf("%s.oe_window", tag), 64'(oe_bad), 64'd0);
    if (we) begin
      ref_mem[int'(addr[15:2])] = wdata;
      exp = last_rdata;
    end else begin
      exp = use_exp ? exp_tbl : ref_read(addr);
    end
    last_rdata = exp;
    last_grant = r;
    chk($sformatf("%s.rdata", tag), 64'(rdata), 64'(exp));
    chk($sformatf("%s.err", tag), 64'(er(r)), 64'd0);
    chk($sformatf("%s.other_done", tag), 64'(dn(1 - r)), 64'd0);
    chk($sformatf("%s.oe_in_done", tag), 64'(mem_wdata_oe), 64'd0);
  endtask

  typedef struct {
    int          r;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [63:0] all_outs();
    return {32'(rdata) | mem_addr | mem_wdata,
            22'h0, req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
            mem_wdata_oe, mem_request, mem_we, 1'b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,          32'h0000_2001};
    tbl[1] = '{1, 1'b1, 32'h0000_3000, 32'h1234_5678,  32'h0};
    tbl[2] = '{1, 1'b0, 32'h0000_3000, 32'h0,          32'h1234_5678};
    tbl[3] = '{0, 1'b1, 32'h0000_3004, 32'hCAFE_F00D,  32'h0};
    tbl[4] = '{0, 1'b0, 32'h0000_2030, 32'h0,          32'h0000_F001};
    tbl[5] = '{1, 1'b0, 32'h0000_3004, 32'h0,          32'hCAFE_F00D};

    rst_n = 1'b0;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      serve(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Simultaneous requests after req1 was served last: req0 first, then req1.
    issue(0, 1'b0, 32'h0000_2000, 32'h0);
    issue(1, 1'b0, 32'h0000_2004, 32'h0);
    serve(0, 1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0000_3001, "dual_a0");
    serve(1, 1'b0, 32'h0000_2004, 32'h0, 1'b1, 32'h0000_4001, "dual_a1");
    // After a lone req0 access, contention must go to req1.
    issue(0, 1'b0, 32'h0000_1000, 32'h0);
    serve(0, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_2001, "solo0");
    issue(0, 1'b0, 32'h0000_2000, 32'h0);
    issue(1, 1'b0, 32'h0000_2004, 32'h0);
    serve(1, 1'b0, 32'h0000_2004, 32'h0, 1'b1, 32'h0000_4001, "dual_b1");
    serve(0, 1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0000_3001, "dual_b0");

    // Asynchronous reset while the handshake is in ASSERT.
    begin
      bit got;
      got = 0;
      issue(0, 1'b0, 32'h0000_1000, 32'h0);
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (req0_ready) got = 1;
      end
      chk("rst_mid.ready", 64'(got), 64'd1);
      drop(0);
      @(negedge clk);
      chk("rst_mid.request_before", 64'(mem_request), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid.request_async", 64'(mem_request), 64'd0);
      chk("rst_mid.outputs_async", all_outs(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_grant = 1;
      last_rdata = 32'h0;
      @(negedge clk);
      issue(0, 1'b0, 32'h0000_2030, 32'h0);
      serve(0, 1'b0, 32'h0000_2030, 32'h0, 1'b1, 32'h0000_F001, "after_rst");
    end

    // Randomized traffic against the reference model.
    for (int it = 0; it < 30; it++) begin
      int          mode, r, w;
      bit          we0, we1;
      logic [31:0] a0, a1, d0, d1;
      mode = int'($urandom_range(0, 3));
      we0 = bit'($urandom_range(0, 1));
      we1 = bit'($urandom_range(0, 1));
      a0  = 32'h4000 + (32'($urandom_range(0, 7)) << 2);
      a1  = 32'h4000 + (32'($urandom_range(0, 7)) << 2);
      d0  = $urandom;
      d1  = $urandom;
      if (mode == 0) begin
        issue(0, we0, a0, d0);
        issue(1, we1, a1, d1);
        w = 1 - last_grant;
        if (w == 0) begin
          serve(0, we0, a0, d0, 1'b0, 32'h0, $sformatf("rnd%0d.w", it));
          serve(1, we1, a1, d1, 1'b0, 32'h0, $sformatf("rnd%0d.l", it));
        end else begin
          serve(1, we1, a1, d1, 1'b0, 32'h0, $sformatf("rnd%0d.w", it));
          serve(0, we0, a0, d0, 1'b0, 32'h0, $sformatf("rnd%0d.l", it));
        end
      end else begin
        r = int'($urandom_range(0, 1));
        issue(r, we0, a0, d0);
        serve(r, we0, a0, d0, 1'b0, 32'h0, $sformatf("rnd%0d", it));
      end
    end

    // Memory that never acks.
    begin
      bit got, done_seen;
      int n;
      ack_stuck = 1;
      got = 0;
      issue(0, 1'b0, 32'h0000_1000, 32'h0);
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (req0_ready) got = 1;
      end
      chk("stuck.ready", 64'(got), 64'd1);
      drop(0);
`ifdef MEMARB_TIMEOUT_EN
      n = 0; done_seen = 0;
      while (n < TMO + 40 && !done_seen) begin
        @(negedge clk);
        n++;
        if (req0_done) done_seen = 1;
      end
      chk("stuck.done", 64'(done_seen), 64'd1);
      chk("stuck.latency", 64'(n), 64'(TMO + 1));
      chk("stuck.err", 64'(req0_err), 64'd1);
      chk("stuck.rdata", 64'(rdata), 64'hDEADBEEF);
      chk("stuck.request", 64'(mem_request), 64'd0);
`else
      done_seen = 0;
      for (n = 0; n < TMO + 20; n++) begin
        @(negedge clk);
        if (req0_done) done_seen = 1;
      end
      chk("stuck.no_done", 64'(done_seen), 64'd0);
      chk("stuck.request_held", 64'(mem_request), 64'd1);
`endif
      ack_stuck = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end

    chk("oe_monitor", 64'(oe_viol_mon), 64'd0);
    chk("oe_at_request", 64'(oe_viol_mem), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
